// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter_if
// Brief    : Client and memory-side signal bundle for memory_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_arbiter_if #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4
);
  logic                    c0_req;
  logic                    c1_req;
  logic                    c0_we;
  logic                    c1_we;
  logic [ADDRESS_SIZE-1:0] c0_addr;
  logic [ADDRESS_SIZE-1:0] c1_addr;
  logic [WORD_SIZE-1:0]    c0_wdata;
  logic [WORD_SIZE-1:0]    c1_wdata;
  logic                    c0_ack;
  logic                    c1_ack;
  logic [WORD_SIZE-1:0]    c0_rdata;
  logic [WORD_SIZE-1:0]    c1_rdata;
  logic                    m_w_en;
  logic                    m_r_en;
  logic [ADDRESS_SIZE-1:0] m_w_addr;
  logic [ADDRESS_SIZE-1:0] m_r_addr;
  logic [WORD_SIZE-1:0]    m_w_data;
  logic [WORD_SIZE-1:0]    m_r_data;
  logic                    m_w_rdy;
  logic                    m_r_rdy;
  logic                    busy;
  logic                    timeout_err;

  // Arbiter side
  modport slave (
    input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
    input  m_r_data, m_w_rdy, m_r_rdy,
    output c0_ack, c1_ack, c0_rdata, c1_rdata,
    output m_w_en, m_r_en, m_w_addr, m_r_addr, m_w_data,
    output busy, timeout_err
  );

  // Environment side: clients plus the memory
  modport master (
    output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
    output m_r_data, m_w_rdy, m_r_rdy,
    input  c0_ack, c1_ack, c0_rdata, c1_rdata,
    input  m_w_en, m_r_en, m_w_addr, m_r_addr, m_w_data,
    input  busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Brief    : Two-client round-robin arbiter in front of one memory, with
//            completion watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int WORD_SIZE      = 8,
  parameter int ADDRESS_SIZE   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic        clock,
  input  wire logic        reset,
  memory_arbiter_if.slave  bus
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit c_wd_en = (TIMEOUT_CYCLES > 0);
  localparam logic [c_cnt_w-1:0] c_cnt_last =
    c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_grant;
  logic                    r_last;
  logic                    r_we;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0]    r_wdata;
  logic [c_cnt_w-1:0]      r_cnt;
  logic                    r_timeout;
  logic [WORD_SIZE-1:0]    r_c0_rdata;
  logic [WORD_SIZE-1:0]    r_c1_rdata;

  logic w_any_req;
  logic w_pick;
  logic w_done;
  logic w_expire;

  assign w_any_req = bus.c0_req | bus.c1_req;
  // On a tie the client that was not granted last wins
  assign w_pick    = (bus.c0_req & bus.c1_req) ? ~r_last : bus.c1_req;
  assign w_done    = r_we ? bus.m_w_rdy : bus.m_r_rdy;
  assign w_expire  = c_wd_en && (r_cnt == c_cnt_last);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_next = S_WAIT;
      S_WAIT:  if (w_done || w_expire) w_state_next = S_ACK;
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_c0_rdata <= '0;
      r_c1_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_any_req) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_we    <= w_pick ? bus.c1_we    : bus.c0_we;
            r_addr  <= w_pick ? bus.c1_addr  : bus.c0_addr;
            r_wdata <= w_pick ? bus.c1_wdata : bus.c0_wdata;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          // A real completion on the expiry cycle takes precedence
          if (w_done) begin
            if (!r_we) begin
              if (r_grant) r_c1_rdata <= bus.m_r_data;
              else         r_c0_rdata <= bus.m_r_data;
            end
          end else if (w_expire) begin
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_w_en      = (r_state == S_WAIT) &  r_we;
  assign bus.m_r_en      = (r_state == S_WAIT) & ~r_we;
  assign bus.m_w_addr    = r_addr;
  assign bus.m_r_addr    = r_addr;
  assign bus.m_w_data    = r_wdata;
  assign bus.c0_ack      = (r_state == S_ACK) & ~r_grant;
  assign bus.c1_ack      = (r_state == S_ACK) &  r_grant;
  assign bus.c0_rdata    = r_c0_rdata;
  assign bus.c1_rdata    = r_c1_rdata;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Randomised bench for memory_arbiter against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;
  localparam int WS   = 8;
  localparam int AS   = 4;
  localparam int TMO  = 8;
  localparam int DEAD = 200;

  logic clock = 1'b0;
  logic reset = 1'b1;

  memory_arbiter_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) bus ();

  memory_arbiter #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .TIMEOUT_CYCLES(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Clients
  bit         pend [2];
  bit         cwe  [2];
  logic [3:0] caddr[2];
  logic [7:0] cdat [2];

  // Knobs
  bit auto_on   = 0;
  int p_start   = 0;
  int p_renew   = 0;
  int p_spur    = 0;
  int p_rst     = 0;
  int lat_fix   = 2;
  bit rst_k1    = 0;
  bit force_rst = 1;

  // Transaction-level model
  bit         rst_q = 1;
  bit         mb, mlast, mwe, mto, mc;
  int         mg, md, free_at, cur_lat;
  logic [3:0] maddr;
  logic [7:0] mwd;
  logic [7:0] exp_rd[2];
  bit         exp_terr;
  logic [7:0] ref_mem[16];

  // Memory instance model
  logic [7:0] mem[16];
  int         mcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive_clients();
    bus.c0_req   = pend[0];  bus.c1_req   = pend[1];
    bus.c0_we    = cwe[0];   bus.c1_we    = cwe[1];
    bus.c0_addr  = caddr[0]; bus.c1_addr  = caddr[1];
    bus.c0_wdata = cdat[0];  bus.c1_wdata = cdat[1];
  endtask

  task automatic start(input int i, input bit we, input int a, input int d);
    pend[i]  = 1'b1;
    cwe[i]   = we;
    caddr[i] = a[3:0];
    cdat[i]  = d[7:0];
    drive_clients();
  endtask

  task automatic new_random(input int i);
    start(i, bit'($urandom_range(1)), int'($urandom_range(15)), int'($urandom_range(255)));
  endtask

  task automatic step();
    bit   pick, e_a0, e_a1, e_wen, e_ren, e_busy, a0, a1, nrst;
    int   k;
    @(negedge clock);
    cyc++;
    // Model update for the edge just passed
    if (rst_q) begin
      mb = 0; mlast = 1; exp_rd[0] = 0; exp_rd[1] = 0; exp_terr = 0; free_at = cyc + 1;
    end else begin
      if (mb && (cyc - mg) == md + 1) mb = 0;
      if (!mb && cyc >= free_at && (pend[0] || pend[1])) begin
        pick  = (pend[0] && pend[1]) ? !mlast : pend[1];
        mlast = pick; mc = pick; mb = 1; mg = cyc;
        mwe   = cwe[pick]; maddr = caddr[pick]; mwd = cdat[pick];
        if (lat_fix != 0)                cur_lat = lat_fix;
        else if ($urandom_range(9) == 0) cur_lat = DEAD;
        else                             cur_lat = int'($urandom_range(6, 1));
        mto     = cur_lat > TMO;
        md      = mto ? TMO : cur_lat;
        free_at = cyc + md + 2;
      end
    end
    e_a0 = 0; e_a1 = 0; e_wen = 0; e_ren = 0; e_busy = 0;
    if (mb) begin
      k = cyc - mg;
      e_busy = 1;
      if (k < md) begin
        e_wen = mwe; e_ren = !mwe;
      end else begin
        e_a0 = (mc == 0); e_a1 = (mc == 1);
        if (mto)      exp_terr = 1;
        else if (mwe) ref_mem[maddr] = mwd;
        else          exp_rd[mc] = ref_mem[maddr];
      end
    end
    check("ctl{ack0,ack1,wen,ren,busy,terr}",
          {bus.c0_ack, bus.c1_ack, bus.m_w_en, bus.m_r_en, bus.busy, bus.timeout_err},
          {e_a0, e_a1, e_wen, e_ren, e_busy, exp_terr});
    check("c0_rdata", bus.c0_rdata, exp_rd[0]);
    check("c1_rdata", bus.c1_rdata, exp_rd[1]);
    if (e_wen) begin
      check("m_w_addr", bus.m_w_addr, maddr);
      check("m_w_data", bus.m_w_data, mwd);
    end
    if (e_ren) check("m_r_addr", bus.m_r_addr, maddr);
    if (rst_q) check("reset_mem_bus", {bus.m_w_addr, bus.m_r_addr, bus.m_w_data}, 0);

    // Memory: rdy after cur_lat enable cycles, junk data and stray pulses otherwise
    bus.m_w_rdy  = 1'b0;
    bus.m_r_rdy  = 1'b0;
    bus.m_r_data = 8'($urandom);
    if (bus.m_w_en || bus.m_r_en) begin
      mcnt++;
      if (mcnt == cur_lat) begin
        if (bus.m_w_en) begin
          mem[bus.m_w_addr] = bus.m_w_data; bus.m_w_rdy = 1'b1;
        end else begin
          bus.m_r_data = mem[bus.m_r_addr]; bus.m_r_rdy = 1'b1;
        end
      end else if (int'($urandom_range(99)) < p_spur) begin
        if (bus.m_w_en) bus.m_r_rdy = 1'b1;
        else            bus.m_w_rdy = 1'b1;
      end
    end else begin
      mcnt = 0;
      if (int'($urandom_range(99)) < p_spur) bus.m_w_rdy = 1'b1;
      if (int'($urandom_range(99)) < p_spur) bus.m_r_rdy = 1'b1;
    end

    a0 = bus.c0_ack; a1 = bus.c1_ack;
    for (int i = 0; i < 2; i++) begin
      if ((i == 0) ? a0 : a1) begin
        pend[i] = 0;
        if (auto_on && int'($urandom_range(99)) < p_renew) new_random(i);
      end else if (!pend[i] && auto_on && int'($urandom_range(99)) < p_start) begin
        new_random(i);
      end
    end
    drive_clients();

    nrst = force_rst;
    if (rst_k1 && mb && !mwe && (cyc - mg) == 1) begin
      nrst = 1; rst_k1 = 0;
    end else if (!(mb && mwe) && int'($urandom_range(999)) < p_rst) begin
      nrst = 1;
    end
    reset = nrst;
    rst_q = nrst;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'h00; ref_mem[i] = 8'h00;
    end
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; cwe[i] = 0; caddr[i] = 0; cdat[i] = 0;
    end
    drive_clients();
    bus.m_w_rdy = 1'b0; bus.m_r_rdy = 1'b0; bus.m_r_data = 8'h00;
    mcnt = 0; cur_lat = 2;

    run(3);
    force_rst = 0;
    run(2);

    // Write then read across clients
    p_spur = 20;
    start(0, 1, 3, 8'hA5); run(8);
    start(1, 0, 3, 0);     run(8);
    check("wr_rd_c1_rdata", bus.c1_rdata, 8'hA5);
    check("wr_rd_c0_rdata", bus.c0_rdata, 8'h00);

    // Sustained tie: grants must alternate
    lat_fix = 1;
    start(0, 0, 3, 0); start(1, 1, 4, 8'h5A);
    auto_on = 1; p_renew = 100; p_start = 0;
    run(24);
    auto_on = 0; run(12);

    // Fixed latency 3 read
    lat_fix = 3;
    start(0, 1, 7, 8'h3C); run(10);
    start(1, 0, 7, 0);     run(10);
    check("lat_c1_rdata", bus.c1_rdata, 8'h3C);

    // Watchdog: memory never responds
    lat_fix = DEAD;
    start(0, 1, 5, 8'h11); run(14);
    check("wd_flag_set", bus.timeout_err, 1);
    lat_fix = 2;
    start(1, 1, 6, 8'h22); run(8);
    start(0, 0, 6, 0);     run(8);
    check("wd_flag_sticky", bus.timeout_err, 1);
    check("wd_c0_rdata", bus.c0_rdata, 8'h22);

    // Stray ready of the wrong kind during a longer read
    lat_fix = 5; p_spur = 100;
    start(0, 0, 7, 0); run(10);
    check("spur_c0_rdata", bus.c0_rdata, 8'h3C);
    p_spur = 20;

    // Reset on the 2nd WAIT cycle of a read, then a tie
    lat_fix = 4; rst_k1 = 1;
    start(0, 0, 3, 0); run(3);
    check("rst_busy", bus.busy, 0);
    check("rst_terr", bus.timeout_err, 0);
    start(1, 1, 9, 8'h77); run(20);

    // Randomised traffic
    lat_fix = 0; auto_on = 1; p_start = 30; p_renew = 50; p_rst = 5;
    run(3000);
    auto_on = 0; p_rst = 0;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
